// File: rtl/mem_port_arbiter.sv
// Arbitrates the single pipelined read port of mem between instruction fetch and loads,
// tagging each in-flight read so its returned word is routed back to the issuing requester.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_flush,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic        busy
);

  localparam int SW = 4;

  logic [MEM_LAT-1:0] vld_q, vld_d;
  logic [MEM_LAT-1:0] id_q, id_d;
  logic [MEM_LAT-1:0] vld_sq;
  logic [SW-1:0]      starve_q, starve_d;
  logic [15:0]        i_rdata_q, i_rdata_d;
  logic [15:0]        d_rdata_q, d_rdata_d;
  logic               fetch_force;

  // A starved fetch overrides the default load priority, but never during a flush.
  always_comb begin
    fetch_force = i_req && !i_flush && (starve_q == SW'(STARVE_MAX));
    i_gnt       = !reset && i_req && !i_flush && (fetch_force || !d_req);
    d_gnt       = !reset && d_req && !fetch_force;
    mem_addr    = 16'h0000;
    if (d_gnt) begin
      mem_addr = d_addr;
    end else if (i_gnt) begin
      mem_addr = i_addr;
    end
  end

  // Flush drops fetch entries (id 0) from every stage; loads are kept.
  assign vld_sq = vld_q & ~({MEM_LAT{i_flush}} & ~id_q);

  // Delivery uses pre-flush state so a fetch word arriving in the flush cycle still lands.
  assign i_rvalid = !reset && vld_q[MEM_LAT-1] && !id_q[MEM_LAT-1];
  assign d_rvalid = !reset && vld_q[MEM_LAT-1] &&  id_q[MEM_LAT-1];
  assign i_rdata  = i_rvalid ? mem_data : i_rdata_q;
  assign d_rdata  = d_rvalid ? mem_data : d_rdata_q;
  assign busy     = !reset && (|vld_sq);

  assign vld_d[0] = i_gnt || d_gnt;
  assign id_d[0]  = d_gnt;

  generate
    for (genvar gi = 1; gi < MEM_LAT; gi++) begin : g_stage
      assign vld_d[gi] = vld_sq[gi-1];
      assign id_d[gi]  = id_q[gi-1];
    end
  endgenerate

  always_comb begin
    starve_d = starve_q;
    if (i_gnt || !i_req || i_flush) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q     <= '0;
      id_q      <= '0;
      starve_q  <= '0;
      i_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
    end else begin
      vld_q     <= vld_d;
      id_q      <= id_d;
      starve_q  <= starve_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  a_one_grant:  assert property (@(posedge clk) !(i_gnt && d_gnt));
  a_one_rvalid: assert property (@(posedge clk) !(i_rvalid && d_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all checked against
// a cycle-indexed schedule of expected deliveries kept by the bench.
module tb_mem_port_arbiter;
  localparam int L = 2;
  localparam int S = 3;

  logic        clk = 1'b0;
  logic        reset, i_req, i_flush, d_req;
  logic [15:0] i_addr, d_addr, mem_data;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, busy;
  logic [15:0] i_rdata, d_rdata, mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(L), .STARVE_MAX(S)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected deliveries by absolute cycle: valid flag and id (0 fetch, 1 load).
  bit sv [0:8191];
  bit sid[0:8191];
  int starve_m;
  logic [15:0] last_i, last_d;

  logic o_ig, o_dg, o_ir, o_dr, o_busy;
  logic [15:0] o_ird, o_drd;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ir, input logic [15:0] ia, input logic fl,
                       input logic dr, input logic [15:0] da, input logic [15:0] md);
    reset = r; i_req = ir; i_addr = ia; i_flush = fl; d_req = dr; d_addr = da; mem_data = md;
  endtask

  task automatic cycle();
    bit e_ig, e_dg, e_ir, e_dr, e_busy;
    logic [15:0] e_addr, e_ird, e_drd;
    @(negedge clk);
    e_ig = 0; e_dg = 0;
    if (!reset) begin
      if (!i_flush && i_req && starve_m == S) e_ig = 1;
      else if (d_req) e_dg = 1;
      else if (i_req && !i_flush) e_ig = 1;
    end
    e_addr = e_dg ? d_addr : (e_ig ? i_addr : 16'h0000);
    e_ir   = !reset && sv[cyc] && !sid[cyc];
    e_dr   = !reset && sv[cyc] &&  sid[cyc];
    e_ird  = e_ir ? mem_data : last_i;
    e_drd  = e_dr ? mem_data : last_d;
    e_busy = 0;
    if (!reset)
      for (int k = cyc; k < cyc + L; k++)
        if (sv[k] && !(i_flush && !sid[k])) e_busy = 1;

    o_ig = i_gnt; o_dg = d_gnt; o_ir = i_rvalid; o_dr = d_rvalid;
    o_ird = i_rdata; o_drd = d_rdata; o_busy = busy;
    chk("i_gnt",    16'(o_ig),   16'(e_ig));
    chk("d_gnt",    16'(o_dg),   16'(e_dg));
    chk("mem_addr", mem_addr,    e_addr);
    chk("i_rvalid", 16'(o_ir),   16'(e_ir));
    chk("d_rvalid", 16'(o_dr),   16'(e_dr));
    chk("i_rdata",  o_ird,       e_ird);
    chk("d_rdata",  o_drd,       e_drd);
    chk("busy",     16'(o_busy), 16'(e_busy));

    if (reset) begin
      for (int k = cyc; k <= cyc + L; k++) sv[k] = 0;
      starve_m = 0; last_i = 16'h0000; last_d = 16'h0000;
    end else begin
      if (i_flush)
        for (int k = cyc + 1; k < cyc + L; k++)
          if (!sid[k]) sv[k] = 0;
      sv[cyc + L]  = e_ig || e_dg;
      sid[cyc + L] = e_dg;
      if (e_ir) last_i = mem_data;
      if (e_dr) last_d = mem_data;
      if (i_req && !e_ig && !i_flush) starve_m = (starve_m < S) ? starve_m + 1 : S;
      else starve_m = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'($urandom));
      cycle();
    end
  endtask

  logic [7:0]  pat8;
  logic [6:0]  pat_ir, pat_dr, pat_b;
  logic        ri, rd, rst, fl;
  logic [15:0] ria, rda;

  initial begin
    for (int k = 0; k < 8192; k++) begin sv[k] = 0; sid[k] = 0; end
    starve_m = 0; last_i = 16'h0000; last_d = 16'h0000;
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    cycle();
    cycle();
    idle(2);

    // Load only: response two cycles after grant, routed to the load side.
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'h1234);
    cycle();
    chk("load_gnt", 16'(o_dg), 16'h1);
    idle(1);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'hBEEF);
    cycle();
    chk("load_rvalid", 16'(o_dr), 16'h1);
    chk("load_rdata", o_drd, 16'hBEEF);
    chk("load_no_i_rvalid", 16'(o_ir), 16'h0);
    idle(1);
    chk("load_rvalid_once", 16'(o_dr), 16'h0);
    chk("load_rdata_held", o_drd, 16'hBEEF);
    idle(2);

    // Contention: fetch forced through every fourth cycle.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 16'h0A00 + 16'(k), 1'b0, 1'b1, 16'h0D00 + 16'(k), 16'($urandom));
      cycle();
      pat8[k] = o_ig;
    end
    chk("contention_i_gnt_pattern", 16'(pat8), 16'h0088);
    idle(3);

    // Pipelined mix: fetch, load, fetch, load on consecutive cycles.
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, (k == 0 || k == 2), 16'(k + 1), 1'b0, (k == 1 || k == 3), 16'(k + 1),
            16'hC000 + 16'(k));
      cycle();
      pat_ir[k] = o_ir; pat_dr[k] = o_dr; pat_b[k] = o_busy;
    end
    chk("mix_i_rvalid_pattern", 16'(pat_ir), 16'h0014);
    chk("mix_d_rvalid_pattern", 16'(pat_dr), 16'h0028);
    chk("mix_busy_pattern", 16'(pat_b), 16'h003E);
    idle(2);

    // Flush: two fetches in flight, flush squashes the younger one only.
    drive(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle();
    drive(1'b0, 1'b1, 16'h0104, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle();
    drive(1'b0, 1'b1, 16'h0108, 1'b1, 1'b0, 16'h0, 16'hAAAA);
    cycle();
    chk("flush_no_gnt", 16'(o_ig), 16'h0);
    chk("flush_cycle_rvalid", 16'(o_ir), 16'h1);
    chk("flush_cycle_rdata", o_ird, 16'hAAAA);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h5555);
    cycle();
    chk("flush_squashed", 16'(o_ir), 16'h0);
    idle(2);

    // Flush with a load in flight: the load survives.
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0200, 16'h0);
    cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
    cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h7777);
    cycle();
    chk("flush_load_survives", 16'(o_dr), 16'h1);
    idle(2);

    // Reset mid-flight drops everything; grant possible right after.
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0300, 16'h0);
    cycle();
    drive(1'b0, 1'b1, 16'h0304, 1'b0, 1'b0, 16'h0, 16'h0);
    cycle();
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h1111);
    cycle();
    chk("reset_no_rvalid", 16'({o_ir, o_dr}), 16'h0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0308, 16'h2222);
    cycle();
    chk("after_reset_gnt", 16'(o_dg), 16'h1);
    chk("after_reset_busy", 16'(o_busy), 16'h0);
    chk("after_reset_no_rvalid", 16'({o_ir, o_dr}), 16'h0);
    idle(3);

    // Random traffic with occasional flushes and resets.
    ri = 0; rd = 0; ria = 16'h0; rda = 16'h0;
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      if (!ri && $urandom_range(0, 9) < 6) begin ri = 1; ria = 16'($urandom); end
      if (!rd && $urandom_range(0, 9) < 5) begin rd = 1; rda = 16'($urandom); end
      drive(rst, ri, ria, fl, rd, rda, 16'($urandom));
      cycle();
      if (o_ig || (fl && $urandom_range(0, 1) == 1)) ri = 0;
      if (o_dg) rd = 0;
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single pipelined read port of `mem` between two requesters: the instruction-fetch path and the load path.
- Issues at most one read per cycle and tracks in-flight reads in a MEM_LAT-deep tag pipeline.
- Routes each returned word to the requester that issued it.
- Default priority goes to loads; a starvation counter guarantees fetch progress.
- Supports a fetch flush for taken jumps.
- Sits between the CPU control FSM / caches and the `mem` instance.

Parameters:
- MEM_LAT, 2, cycles from `mem_addr` presentation to valid `mem_data`; legal range 1..4.
- STARVE_MAX, 3, consecutive denied fetch cycles before fetch is forced to win; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- i_req  input  1  fetch read request; held until granted.
- i_addr  input  16  fetch address; stable while i_req is high.
- i_flush  input  1  squash all in-flight fetch reads and block any fetch grant this cycle.
- i_gnt  output  1  fetch request accepted this cycle (combinational).
- i_rvalid  output  1  fetch read data valid.
- i_rdata  output  16  fetch read data.
- d_req  input  1  load read request; held until granted.
- d_addr  input  16  load address; stable while d_req is high.
- d_gnt  output  1  load request accepted this cycle (combinational).
- d_rvalid  output  1  load read data valid.
- d_rdata  output  16  load read data.
- mem_addr  output  16  address to `mem`.
- mem_data  input  16  `mem` read data, MEM_LAT cycles after its address.
- busy  output  1  any read in flight in the tag pipeline.

Behaviour:
- Clock/reset: single clock `clk`; `reset` is synchronous, active-high.
- Reset values: tag pipeline all invalid, starve counter 0, i_rvalid = d_rvalid = 0, busy = 0.
- Grants are combinational and gated by reset: i_gnt = d_gnt = 0 whenever reset is high.
- Handshake:
  - A request is accepted in the cycle req && gnt; the requester may change its address the following cycle.
  - req is never withdrawn before grant, except fetch on flush.
  - At most one grant per cycle.
- Arbitration, evaluated each cycle:
  - If i_flush is high, i_gnt = 0.
  - Else if i_req is high and starve == STARVE_MAX, fetch wins.
  - Else if d_req is high, load wins.
  - Else if i_req is high, fetch wins.
  - Otherwise no grant.
- Starve counter:
  - Increments, saturating at STARVE_MAX, when i_req && !i_gnt && !i_flush.
  - Clears to 0 on i_gnt, on !i_req, or on i_flush.
- Address mux:
  - mem_addr = granted address.
  - With no grant, mem_addr = 16'h0000.
- Tag pipeline: MEM_LAT stages of {valid, id}, id 0 = fetch, 1 = load.
  - Stage 0 loads {grant, winner} each cycle.
  - Entries shift one stage per cycle and are never stalled.
  - Requesters must accept data unconditionally; there is no backpressure.
- Response timing (latency exactly MEM_LAT cycles):
  - An entry granted in cycle t produces rvalid in cycle t+MEM_LAT.
  - Data is {i,d}_rdata = mem_data from that same cycle.
  - rdata is registered-through: it holds the last delivered value when rvalid is low. Reset value 0.
- Flush:
  - i_flush clears the valid bit of every fetch entry in all stages in the same edge; load entries are untouched.
  - A fetch entry reaching the output in the flush cycle itself is still delivered: i_rvalid is computed from pre-flush state.
  - No i_rvalid arises from any grant issued before the flush cycle after that cycle.
- busy = OR of all stage valid bits after squash.
- Back-to-back operation:
  - A grant every cycle is legal.
  - A response delivery and a new grant in the same cycle are independent.
  - Fetch and load responses never collide, since there is one grant per cycle.
- Reset mid-operation:
  - All in-flight entries are dropped and no rvalid is produced for them.
  - The first grant after reset deasserts is possible in that same cycle.
- Checks:
  - Assertion: i_gnt && d_gnt never both high.
  - Assertion: i_rvalid && d_rvalid never both high.

Test Plan:
- Load only, MEM_LAT=2: d_req with d_addr=16'h0010 at cycle 5, mem returns 16'hBEEF at cycle 7 -> d_gnt=1 at cycle 5; d_rvalid=1 with d_rdata=16'hBEEF at cycle 7 only; i_rvalid stays 0.
- Contention, STARVE_MAX=3:
  - Stimulus: i_req and d_req both held high for 8 cycles starting at cycle 0.
  - Required: d_gnt at cycles 0,1,2; i_gnt at cycle 3; d_gnt at cycles 4,5,6; i_gnt at cycle 7.
  - Required: responses arrive at +2 cycles with matching id.
- Pipelined mix: alternating fetch/load grants on 4 consecutive cycles with addresses 1,2,3,4 -> rvalids alternate i,d,i,d on cycles +2 with the correct data; busy stays high throughout and falls 2 cycles after the last grant.
- Flush: fetch granted at cycles 10 and 11, i_flush=1 at cycle 12 with i_req high -> i_gnt=0 at cycle 12; i_rvalid at cycle 12 for the cycle-10 grant; no i_rvalid at cycle 13.
- Flush with load in flight: load granted at cycle 20, i_flush at cycle 21 -> d_rvalid still asserted at cycle 22.
- Reset mid-flight: grants at cycles 30 and 31, reset high at cycle 32 -> no rvalid at cycles 32–33; busy=0 from cycle 33; starve counter reads 0; a d_req at cycle 33 with reset low is granted that cycle.
